mips_state_dumper: RTL

- Debug block that snapshots MIPS architectural state on demand and streams it out as tagged 32-bit beats over a valid/ready interface.
- Beat order: PC, then registers 0..NUM_REGS-1, then DM_WORDS big-endian words assembled from the byte-wide data memory starting at DM_BASE.
- Attaches beside the CPU through dedicated read ports on the PC, register file and data memory. Replaces end-of-run hierarchical peeks with a synthesizable, parametrised dump engine.

---
 rtl/mips_state_dumper.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mips_state_dumper.sv
// mips_state_dumper: snapshots the MIPS PC, register file and byte-wide data
// memory on request and streams them out as tagged 32-bit valid/ready beats.
// Beat order: PC, registers 0..NUM_REGS-1, then DM_WORDS big-endian words.
// Optional feature: define MIPS_STATE_DUMPER_CHECKSUM_EN to append a final
// beat (tag 3) carrying the XOR of every data beat sent in the dump.
module mips_state_dumper #(
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned DM_ADDR_W = 10,
    parameter int unsigned DM_BASE   = 0,
    parameter int unsigned DM_WORDS  = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          pc_in,
    output logic [4:0]           rf_raddr,
    input  logic [31:0]          rf_rdata,
    output logic [DM_ADDR_W-1:0] dm_raddr,
    input  logic [7:0]           dm_rdata,
    output logic                 dump_valid,
    input  logic                 dump_ready,
    output logic [31:0]          dump_data,
    output logic [1:0]           dump_tag,
    output logic [7:0]           dump_index,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        StIdle,
        StCapPc,
        StRdReg,
        StRdDm,
        StEmit,
        StDone
    } state_e;

    localparam logic [1:0] TagPc  = 2'd0;
    localparam logic [1:0] TagReg = 2'd1;
    localparam logic [1:0] TagDm  = 2'd2;
    localparam logic [1:0] TagSum = 2'd3;

    localparam logic [7:0] LastReg  = 8'(NUM_REGS - 1);
    localparam logic [7:0] LastWord = 8'(DM_WORDS - 1);
    localparam bit         HasDm    = (DM_WORDS != 0);

    state_e                 state_q, state_d;
    logic [31:0]            data_q, data_d;
    logic [1:0]             tag_q, tag_d;
    logic [7:0]             index_q, index_d;
    logic [1:0]             byte_q, byte_d;
    logic [4:0]             rf_raddr_q, rf_raddr_d;
    logic [DM_ADDR_W-1:0]   dm_raddr_q, dm_raddr_d;
    logic [7:0]             next_index;
    logic                   finish;
`ifdef MIPS_STATE_DUMPER_CHECKSUM_EN
    logic [31:0]            xor_q, xor_d;
`endif

    // Byte address of byte b in dumped word; wraps modulo the memory size.
    function automatic logic [DM_ADDR_W-1:0] dm_addr(input logic [7:0] word,
                                                     input logic [1:0] b);
        return DM_ADDR_W'(DM_BASE + {22'd0, word, 2'b00} + {30'd0, b});
    endfunction

    assign next_index = index_q + 8'd1;

    // State register and beat/address holding registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            data_q     <= '0;
            tag_q      <= '0;
            index_q    <= '0;
            byte_q     <= '0;
            rf_raddr_q <= '0;
            dm_raddr_q <= '0;
`ifdef MIPS_STATE_DUMPER_CHECKSUM_EN
            xor_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            tag_q      <= tag_d;
            index_q    <= index_d;
            byte_q     <= byte_d;
            rf_raddr_q <= rf_raddr_d;
            dm_raddr_q <= dm_raddr_d;
`ifdef MIPS_STATE_DUMPER_CHECKSUM_EN
            xor_q      <= xor_d;
`endif
        end
    end

    // Next-state logic: capture a beat, present it, then step to the next item.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        tag_d      = tag_q;
        index_d    = index_q;
        byte_d     = byte_q;
        rf_raddr_d = rf_raddr_q;
        dm_raddr_d = dm_raddr_q;
        finish     = 1'b0;
`ifdef MIPS_STATE_DUMPER_CHECKSUM_EN
        xor_d      = xor_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StCapPc;
`ifdef MIPS_STATE_DUMPER_CHECKSUM_EN
                    xor_d   = '0;
`endif
                end
            end
            StCapPc: begin
                data_d  = pc_in;
                tag_d   = TagPc;
                index_d = '0;
                state_d = StEmit;
            end
            StRdReg: begin
                // tag/index were set on entry; rf_raddr already points at the register
                data_d  = rf_rdata;
                state_d = StEmit;
            end
            StRdDm: begin
                // shift left so byte 0 ends up in bits 31:24
                data_d = {data_q[23:0], dm_rdata};
                if (byte_q == 2'd3) begin
                    state_d = StEmit;
                end else begin
                    byte_d     = byte_q + 2'd1;
                    dm_raddr_d = dm_addr(index_q, byte_q + 2'd1);
                end
            end
            StEmit: begin
                if (dump_ready) begin
`ifdef MIPS_STATE_DUMPER_CHECKSUM_EN
                    if (tag_q != TagSum) xor_d = xor_q ^ data_q;
`endif
                    unique case (tag_q)
                        TagPc: begin
                            state_d    = StRdReg;
                            tag_d      = TagReg;
                            index_d    = '0;
                            rf_raddr_d = '0;
                        end
                        TagReg: begin
                            if (index_q != LastReg) begin
                                state_d    = StRdReg;
                                index_d    = next_index;
                                rf_raddr_d = next_index[4:0];
                            end else if (HasDm) begin
                                state_d    = StRdDm;
                                tag_d      = TagDm;
                                index_d    = '0;
                                byte_d     = '0;
                                dm_raddr_d = dm_addr(8'd0, 2'd0);
                            end else begin
                                finish = 1'b1;
                            end
                        end
                        TagDm: begin
                            if (index_q != LastWord) begin
                                state_d    = StRdDm;
                                index_d    = next_index;
                                byte_d     = '0;
                                dm_raddr_d = dm_addr(next_index, 2'd0);
                            end else begin
                                finish = 1'b1;
                            end
                        end
                        TagSum: state_d = StDone;
                    endcase
                    if (finish) begin
`ifdef MIPS_STATE_DUMPER_CHECKSUM_EN
                        state_d = StEmit;
                        tag_d   = TagSum;
                        index_d = '0;
                        data_d  = xor_q ^ data_q;
`else
                        state_d = StDone;
`endif
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign rf_raddr   = rf_raddr_q;
    assign dm_raddr   = dm_raddr_q;
    assign dump_valid = (state_q == StEmit);
    assign dump_data  = data_q;
    assign dump_tag   = tag_q;
    assign dump_index = index_q;
    assign busy       = (state_q != StIdle) && (state_q != StDone);
    assign done       = (state_q == StDone);

endmodule
